// File: rtl/counter_cfg_arb_if.sv
// Request/write bus between the two requesters, the arbiter and the counter.
// master: requester/counter side, slave: counter_cfg_arb.
interface counter_cfg_arb_if;
  logic        req0_valid;
  logic [1:0]  req0_ch;
  logic [31:0] req0_val;
  logic        req0_ready;
  logic        req1_valid;
  logic [1:0]  req1_ch;
  logic [31:0] req1_val;
  logic        req1_ready;
  logic        counter_we;
  logic [1:0]  counter_ch;
  logic [31:0] counter_val;

  modport master (
    output req0_valid, req0_ch, req0_val, req1_valid, req1_ch, req1_val,
    input  req0_ready, req1_ready, counter_we, counter_ch, counter_val
  );

  modport slave (
    input  req0_valid, req0_ch, req0_val, req1_valid, req1_ch, req1_val,
    output req0_ready, req1_ready, counter_we, counter_ch, counter_val
  );
endinterface

// File: rtl/counter_cfg_arb.sv
// Write-side controller for the three-channel counter: round-robin arbiter,
// write serialiser with a GAP_CYCLES idle gap, and sticky maskable overflow
// interrupt flags.
// Optional feature: define COUNTER_ARB_SYNC_EN to put a two-flop synchroniser
// on each counterN_OUT (counter on another clock domain).
module counter_cfg_arb #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  counter_cfg_arb_if.slave  bus,
  input  logic              counter0_OUT,
  input  logic              counter1_OUT,
  input  logic              counter2_OUT,
  input  logic [2:0]        irq_mask,
  input  logic [2:0]        irq_clr,
  output logic [2:0]        irq_pending,
  output logic              irq,
  output logic              wr_done
);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t      state, state_nxt;
  logic        ptr;         // favoured requester
  logic [3:0]  gap_cnt;
  logic [1:0]  ch_q;
  logic [31:0] val_q;
  logic        grant0, grant1, we, done;

  // Next state, grants and write strobe
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
        if (grant0 || grant1) state_nxt = WRITE;
      end
      WRITE: begin
        we        = 1'b1;
        state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt <= 4'd1) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req0_ready  = grant0 && !rst;
  assign bus.req1_ready  = grant1 && !rst;
  assign bus.counter_we  = we;
  assign bus.counter_ch  = ch_q;
  assign bus.counter_val = val_q;
  // A reset landing on the last gap cycle must not leak a completion pulse.
  assign wr_done         = done && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture accepted request, rotate pointer, run the gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 1'b0;
      gap_cnt <= 4'd0;
      ch_q    <= 2'd0;
      val_q   <= 32'd0;
    end else begin
      if (grant0 || grant1) begin
        ptr   <= grant0;  // winner 0 -> favour 1 next, and vice versa
        ch_q  <= grant0 ? bus.req0_ch  : bus.req1_ch;
        val_q <= grant0 ? bus.req0_val : bus.req1_val;
      end
      if (state == WRITE)    gap_cnt <= 4'(GAP_CYCLES);
      else if (state == GAP) gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // ---------------- interrupts ----------------
  logic [2:0] out_raw, out_s, out_d, rise, wr_clr, pend_nxt;

  assign out_raw = {counter2_OUT, counter1_OUT, counter0_OUT};

`ifdef COUNTER_ARB_SYNC_EN
  logic [2:0] sync1, sync2;

  // Two-flop synchroniser for overflow bits from a foreign clock
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 3'd0;
      sync2 <= 3'd0;
    end else begin
      sync1 <= out_raw;
      sync2 <= sync1;
    end
  end
  assign out_s = sync2;
`else
  assign out_s = out_raw;
`endif

  // Delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) out_d <= 3'd0;
    else     out_d <= out_s;
  end

  assign rise = out_s & ~out_d;
  // Reprogramming a channel acknowledges its overflow; control word clears nothing.
  assign wr_clr   = (state == WRITE && ch_q != 2'd3) ? 3'(3'b001 << ch_q) : 3'd0;
  // Set wins over any clear in the same cycle.
  assign pend_nxt = (irq_pending & ~(irq_clr | wr_clr)) | rise;

  // Sticky pending flags and registered interrupt line
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pending <= 3'd0;
      irq         <= 1'b0;
    end else begin
      irq_pending <= pend_nxt;
      irq         <= |(irq_pending & irq_mask);
    end
  end

endmodule

// File: tb/tb_counter_cfg_arb.sv
// Directed bench for counter_cfg_arb, built with GAP_CYCLES=4.
module tb_counter_cfg_arb;
  localparam int G = 4;
`ifdef COUNTER_ARB_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       c0, c1, c2;
  logic [2:0] irq_mask, irq_clr, irq_pending;
  logic       irq, wr_done;
  int         total = 0;
  int         bad   = 0;

  counter_cfg_arb_if bus ();

  counter_cfg_arb #(.GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .counter0_OUT(c0), .counter1_OUT(c1), .counter2_OUT(c2),
    .irq_mask(irq_mask), .irq_clr(irq_clr),
    .irq_pending(irq_pending), .irq(irq), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for ready, accept; returns in the WRITE cycle.
  task automatic do_write(input int p, input logic [1:0] ch, input logic [31:0] v);
    int k;
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_ch = ch; bus.req0_val = v;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_ch = ch; bus.req1_val = v;
    end
    #1;
    for (k = 0; k < 20 && !(p == 0 ? bus.req0_ready : bus.req1_ready); k++) tick();
    chk("wr_ready", p == 0 ? bus.req0_ready : bus.req1_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Wait (bounded) for wr_done, then step into IDLE.
  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 30 && !wr_done; k++) tick();
    chk(tag, wr_done, 1);
    tick();
  endtask

  initial begin
    int n, last;
    logic [1:0]  exp_ch [4];
    logic [31:0] exp_val[4];
    exp_ch  = '{2'd2, 2'd1, 2'd2, 2'd1};
    exp_val = '{32'd7, 32'd5, 32'd7, 32'd5};

    // ---- reset ----
    rst = 1'b1; c0 = 0; c1 = 0; c2 = 0; irq_mask = 3'b101; irq_clr = 3'b000;
    bus.req0_valid = 1'b1; bus.req0_ch = 0; bus.req0_val = 0;
    bus.req1_valid = 1'b0; bus.req1_ch = 0; bus.req1_val = 0;
    tick(); tick();
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_we", bus.counter_we, 0);
    chk("rst_ch", bus.counter_ch, 0);
    chk("rst_val", bus.counter_val, 0);
    chk("rst_pending", irq_pending, 0);
    chk("rst_irq", irq, 0);
    chk("rst_done", wr_done, 0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;

    // ---- single write, with a withdrawn req1 during GAP ----
    bus.req0_valid = 1'b1; bus.req0_ch = 2'd0; bus.req0_val = 32'h10;
    #1;
    chk("sw_ready0", bus.req0_ready, 1);
    chk("sw_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    chk("sw_we", bus.counter_we, 1);
    chk("sw_ch", bus.counter_ch, 0);
    chk("sw_val", bus.counter_val, 32'h10);
    for (int i = 1; i <= G; i++) begin
      tick();
      chk("sw_gap_we", bus.counter_we, 0);
      chk("sw_gap_val", bus.counter_val, 32'h10);
      chk("sw_done", wr_done, (i == G) ? 1 : 0);
      if (i == 2) begin
        bus.req1_valid = 1'b1; bus.req1_ch = 2'd1; bus.req1_val = 32'h99;
        #1;
        chk("wd_ready1", bus.req1_ready, 0);
      end
      if (i == 3) bus.req1_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wd_no_we", bus.counter_we, 0);
      chk("wd_no_done", wr_done, 0);
    end

    // ---- contention: pointer favours port 1 after the port-0 write ----
    bus.req0_valid = 1'b1; bus.req0_ch = 2'd1; bus.req0_val = 32'd5;
    bus.req1_valid = 1'b1; bus.req1_ch = 2'd2; bus.req1_val = 32'd7;
    n = 0; last = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      tick();
      if (bus.counter_we) begin
        chk("ct_ch", bus.counter_ch, exp_ch[n]);
        chk("ct_val", bus.counter_val, exp_val[n]);
        if (n > 0) chk("ct_spacing", c - last, G + 2);
        last = c;
        n++;
        if (n == 4) begin
          bus.req0_valid = 1'b0;
          bus.req1_valid = 1'b0;
        end
      end
    end
    chk("ct_count", n, 4);
    wait_done("ct_done");

    // ---- interrupts, mask 101 ----
    c2 = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk("irq_early", irq_pending, 0);
    end
    tick();
    chk("irq_pend", irq_pending, 3'b100);
    tick();
    chk("irq_line", irq, 1);
    irq_clr = 3'b100;
    tick();
    irq_clr = 3'b000;
    chk("clr_pend", irq_pending, 0);
    tick();
    chk("clr_irq", irq, 0);
    // rising edge coincident with clear: set wins
    c2 = 1'b0;
    repeat (LAT + 1) tick();
    c2 = 1'b1;
    repeat (LAT - 1) tick();
    irq_clr = 3'b100;
    tick();
    irq_clr = 3'b000;
    chk("setwin_pend", irq_pending, 3'b100);
    tick();
    chk("setwin_irq", irq, 1);
    irq_clr = 3'b100;
    tick();
    irq_clr = 3'b000;
    tick();
    chk("clr2_irq", irq, 0);
    // masked channel sets pending but not irq
    c1 = 1'b1;
    repeat (LAT) tick();
    chk("mask_pend", irq_pending, 3'b010);
    repeat (2) tick();
    chk("mask_irq", irq, 0);

    // ---- reprogram acknowledge ----
    c0 = 1'b1;
    repeat (LAT) tick();
    chk("ack_pend0", irq_pending, 3'b011);
    do_write(0, 2'd3, 32'hABCD);
    chk("ack_cw_we", bus.counter_we, 1);
    chk("ack_cw_ch", bus.counter_ch, 3);
    wait_done("ack_cw_done");
    chk("ack_cw_pend", irq_pending, 3'b011);
    do_write(1, 2'd0, 32'h1234);
    chk("ack_w_pend", irq_pending, 3'b011);
    tick();
    chk("ack_after", irq_pending, 3'b010);
    wait_done("ack_w_done");

    // ---- reset in GAP ----
    c0 = 0; c1 = 0; c2 = 0;
    repeat (LAT + 1) tick();
    irq_clr = 3'b111;
    tick();
    irq_clr = 3'b000;
    do_write(0, 2'd1, 32'h55);   // leaves pointer favouring port 1
    tick(); tick();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_ch = 2'd2; bus.req0_val = 32'h66;
    bus.req1_valid = 1'b1; bus.req1_ch = 2'd3; bus.req1_val = 32'h77;
    #1;
    chk("rg_ready0_rst", bus.req0_ready, 0);
    chk("rg_done_rst", wr_done, 0);
    tick();
    chk("rg_we", bus.counter_we, 0);
    chk("rg_ch", bus.counter_ch, 0);
    chk("rg_val", bus.counter_val, 0);
    chk("rg_done", wr_done, 0);
    chk("rg_pend", irq_pending, 0);
    chk("rg_irq", irq, 0);
    rst = 1'b0;
    #1;
    chk("rg_ptr0", bus.req0_ready, 1);
    chk("rg_ptr1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < G + 2; i++) begin
      tick();
      chk("rg_no_done", wr_done, 0);
      chk("rg_no_we", bus.counter_we, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
